// File: rtl/gpu_axil_pkg.sv
// Shared AXI-Lite definitions for the GPU register/memory bridge.
// Response codes and the read-side FSM state encoding used by both controllers.
package gpu_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        RD_RESP  = 3'd3,
        RD_ERR   = 3'd4
    } rd_state_e;

endpackage

// File: rtl/axil_read_controller.sv
// AXI-Lite read slave that turns one AR request into a single-cycle memory read strobe
// and returns the word after a fixed memory latency; out-of-range addresses get SLVERR.
module axil_read_controller
    import gpu_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MEM_WORDS    = 2**22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] axil_araddr,
    input  logic [2:0]            axil_arprot,
    input  logic                  axil_arvalid,
    output logic                  axil_arready,
    output logic [DATA_WIDTH-1:0] axil_rdata,
    output logic [1:0]            axil_rresp,
    output logic                  axil_rvalid,
    input  logic                  axil_rready,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned      CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    rd_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            resp_q, resp_d;

    logic                  arready_d;
    logic                  ren_d;
    logic [ADDR_WIDTH-1:0] raddr_d;
    logic                  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]            rresp_d;

    logic                  in_range_c;
    logic                  unused_ok;

    assign in_range_c = 64'(axil_araddr[ADDR_WIDTH-1:2]) < 64'(MEM_WORDS);
    assign unused_ok  = ^{axil_arprot, axil_araddr[1:0]};

    // Next-state logic; bus outputs are derived from the next state so they leave flops
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        resp_d  = resp_q;

        case (state_q)
            RD_IDLE: begin
                if (axil_arvalid && axil_arready) begin
                    addr_d = {axil_araddr[ADDR_WIDTH-1:2], 2'b00};
                    data_d = '0;
                    if (in_range_c) begin
                        resp_d  = RESP_OKAY;
                        state_d = RD_ISSUE;
                    end else begin
                        resp_d  = RESP_SLVERR;
                        state_d = RD_ERR;
                    end
                end
            end
            RD_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = rdata;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_RESP, RD_ERR: begin
                if (axil_rvalid && axil_rready) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase

        arready_d = (state_d == RD_IDLE);
        ren_d     = (state_d == RD_ISSUE);
        raddr_d   = (state_d == RD_ISSUE) ? addr_d : '0;
        rvalid_d  = (state_d == RD_RESP) || (state_d == RD_ERR);
        rdata_d   = (state_d == RD_RESP) ? data_d : '0;
        rresp_d   = rvalid_d ? resp_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RD_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            resp_q       <= '0;
            axil_arready <= 1'b0;
            ren          <= 1'b0;
            raddr        <= '0;
            axil_rvalid  <= 1'b0;
            axil_rdata   <= '0;
            axil_rresp   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            resp_q       <= resp_d;
            axil_arready <= arready_d;
            ren          <= ren_d;
            raddr        <= raddr_d;
            axil_rvalid  <= rvalid_d;
            axil_rdata   <= rdata_d;
            axil_rresp   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axil_read_controller.sv
// Bench for axil_read_controller: two instances (latency 1 / full map, latency 3 / 16 words)
// against a memory model and an address/latency reference model.
module tb_axil_read_controller;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] araddr    [2];
    logic [2:0]    arprot    [2];
    logic          arvalid   [2];
    logic          arready   [2];
    logic [DW-1:0] axrdata   [2];
    logic [1:0]    rresp     [2];
    logic          rvalid    [2];
    logic          rready    [2];
    logic [AW-1:0] raddr     [2];
    logic          ren       [2];
    logic [DW-1:0] mem_rdata [2];

    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            viol = 0;
    int            ren_cnt [2] = '{0, 0};
    logic [AW-1:0] last_raddr [2];
    logic          prev_ren [2] = '{1'b0, 1'b0};

    logic [3:0]    pv [2] = '{4'h0, 4'h0};
    logic [AW-1:0] pa [2][4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_read_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .MEM_WORDS(2**22)) u_a (
        .clk(clk), .rst(rst),
        .axil_araddr(araddr[0]), .axil_arprot(arprot[0]), .axil_arvalid(arvalid[0]), .axil_arready(arready[0]),
        .axil_rdata(axrdata[0]), .axil_rresp(rresp[0]), .axil_rvalid(rvalid[0]), .axil_rready(rready[0]),
        .raddr(raddr[0]), .ren(ren[0]), .rdata(mem_rdata[0])
    );

    axil_read_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3), .MEM_WORDS(16)) u_b (
        .clk(clk), .rst(rst),
        .axil_araddr(araddr[1]), .axil_arprot(arprot[1]), .axil_arvalid(arvalid[1]), .axil_arready(arready[1]),
        .axil_rdata(axrdata[1]), .axil_rresp(rresp[1]), .axil_rvalid(rvalid[1]), .axil_rready(rready[1]),
        .raddr(raddr[1]), .ren(ren[1]), .rdata(mem_rdata[1])
    );

    // Memory: word valid exactly READ_LATENCY cycles after the ren cycle, garbage otherwise
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pv[d]    <= {pv[d][2:0], ren[d]};
            pa[d][0] <= raddr[d];
            for (int k = 1; k < 4; k++) pa[d][k] <= pa[d][k-1];
        end
    end
    assign mem_rdata[0] = pv[0][0] ? (32'hCAFE0000 | 32'(pa[0][0])) : 32'hDEADBEEF;
    assign mem_rdata[1] = pv[1][2] ? (32'hCAFE0000 | 32'(pa[1][2])) : 32'hDEADBEEF;

    // Protocol watcher: ren pulses, idle-zero rules, no AR acceptance while a response is pending
    always @(negedge clk) begin
        int v;
        v = 0;
        for (int d = 0; d < 2; d++) begin
            if (ren[d] === 1'b1) begin
                ren_cnt[d]    <= ren_cnt[d] + 1;
                last_raddr[d] <= raddr[d];
                if (prev_ren[d]) v++;
            end else if (raddr[d] !== '0) v++;
            if (rvalid[d] !== 1'b1 && (axrdata[d] !== '0 || rresp[d] !== 2'b00)) v++;
            if (rvalid[d] === 1'b1 && arready[d] === 1'b1) v++;
            prev_ren[d] <= ren[d];
        end
        viol <= viol + v;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int words_of(input int d);
        return (d == 0) ? 4194304 : 16;
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~AW'(3);
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hCAFE0000 | 32'(align(a));
    endfunction

    // One AR/R transaction, entered and left at a falling edge; reports what the bus did
    task automatic run_read(input int d, input logic [AW-1:0] addr, input int stall, input bit early,
                            input logic [AW-1:0] probe_addr, input bit probe,
                            output int hs, output int rv, output logic [DW-1:0] data,
                            output logic [1:0] resp, output bit ok_stall, output bit to);
        int n;
        to = 1'b0; ok_stall = 1'b1; hs = -1; rv = -1; data = '0; resp = '0;
        araddr[d]  = addr;
        arprot[d]  = 3'($urandom());
        arvalid[d] = 1'b1;
        rready[d]  = early;
        n = 0;
        while (arready[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin to = 1'b1; arvalid[d] = 1'b0; rready[d] = 1'b0; return; end
        hs = cyc;
        @(negedge clk);
        arvalid[d] = 1'b0;
        n = 0;
        while (rvalid[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin to = 1'b1; rready[d] = 1'b0; return; end
        rv   = cyc;
        data = axrdata[d];
        resp = rresp[d];
        if (probe) begin araddr[d] = probe_addr; arvalid[d] = 1'b1; end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (rvalid[d] !== 1'b1 || axrdata[d] !== data || rresp[d] !== resp || arready[d] !== 1'b0)
                ok_stall = 1'b0;
        end
        rready[d] = 1'b1;
        @(negedge clk);
        rready[d] = 1'b0;
        if (rvalid[d] !== 1'b0) ok_stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            araddr[d] = '0; arprot[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (arready[d] !== 1'b0 || rvalid[d] !== 1'b0 || ren[d] !== 1'b0 || raddr[d] !== '0 ||
                axrdata[d] !== '0 || rresp[d] !== 2'b00) begin
                failures++;
                $display("FAIL reset_outputs[%0d] arready=%b rvalid=%b ren=%b raddr=%h rdata=%h rresp=%b required all 0",
                         d, arready[d], rvalid[d], ren[d], raddr[d], axrdata[d], rresp[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (arready[d] !== 1'b1) begin
                failures++;
                $display("FAIL arready_after_reset[%0d] got=%b required=1", d, arready[d]);
            end
        end
    endtask

    task automatic test_directed();
        int hs, rv, c0;
        logic [DW-1:0] dat;
        logic [1:0] rsp;
        bit okst, to;
        c0 = ren_cnt[0];
        run_read(0, 24'h000104, 0, 1'b1, '0, 1'b0, hs, rv, dat, rsp, okst, to);
        checks++;
        if (to || ren_cnt[0] - c0 != 1 || last_raddr[0] !== 24'h000104) begin
            failures++;
            $display("FAIL ren_104 timeout=%0d pulses=%0d raddr=%h required 1 pulse raddr=000104", to, ren_cnt[0] - c0, last_raddr[0]);
        end
        checks++;
        if (dat !== 32'hCAFE0104 || rsp !== 2'b00) begin
            failures++;
            $display("FAIL rdata_104 got=%h/%b required=cafe0104/00", dat, rsp);
        end
        checks++;
        if (rv - hs != 3) begin
            failures++;
            $display("FAIL latency_104 got=%0d required=3", rv - hs);
        end
        c0 = ren_cnt[0];
        run_read(0, 24'h000107, 0, 1'b0, '0, 1'b0, hs, rv, dat, rsp, okst, to);
        checks++;
        if (to || last_raddr[0] !== 24'h000104 || dat !== 32'hCAFE0104 || ren_cnt[0] - c0 != 1) begin
            failures++;
            $display("FAIL unaligned_107 timeout=%0d raddr=%h rdata=%h required raddr=000104 rdata=cafe0104", to, last_raddr[0], dat);
        end
    endtask

    task automatic test_range_boundary();
        int hs, rv, c0;
        logic [DW-1:0] dat;
        logic [1:0] rsp;
        bit okst, to;
        c0 = ren_cnt[1];
        run_read(1, 24'h000040, 0, 1'b0, '0, 1'b0, hs, rv, dat, rsp, okst, to);
        checks++;
        if (to || ren_cnt[1] != c0 || rsp !== 2'b10 || dat !== '0) begin
            failures++;
            $display("FAIL slverr_40 timeout=%0d pulses=%0d rresp=%b rdata=%h required 0 pulses rresp=10 rdata=0",
                     to, ren_cnt[1] - c0, rsp, dat);
        end
        checks++;
        if (rv - hs != 1) begin
            failures++;
            $display("FAIL slverr_latency got=%0d required=1", rv - hs);
        end
        c0 = ren_cnt[1];
        run_read(1, 24'h00003F, 0, 1'b1, '0, 1'b0, hs, rv, dat, rsp, okst, to);
        checks++;
        if (to || ren_cnt[1] - c0 != 1 || last_raddr[1] !== 24'h00003C || dat !== 32'hCAFE003C || rsp !== 2'b00) begin
            failures++;
            $display("FAIL last_word_3f raddr=%h rdata=%h rresp=%b required raddr=00003c rdata=cafe003c rresp=00",
                     last_raddr[1], dat, rsp);
        end
        checks++;
        if (rv - hs != 5) begin
            failures++;
            $display("FAIL latency3 got=%0d required=5", rv - hs);
        end
    endtask

    task automatic test_stall();
        int hs, rv, hs2, rv2, c0;
        logic [DW-1:0] dat;
        logic [1:0] rsp;
        bit okst, to;
        c0 = ren_cnt[0];
        run_read(0, 24'h000200, 10, 1'b0, 24'h000300, 1'b1, hs, rv, dat, rsp, okst, to);
        checks++;
        if (to || !okst || dat !== 32'hCAFE0200 || rsp !== 2'b00 || ren_cnt[0] - c0 != 1) begin
            failures++;
            $display("FAIL stall_10 timeout=%0d stable=%0d rdata=%h pulses=%0d required stable rdata=cafe0200 1 pulse",
                     to, okst, dat, ren_cnt[0] - c0);
        end
        run_read(0, 24'h000300, 0, 1'b1, '0, 1'b0, hs2, rv2, dat, rsp, okst, to);
        checks++;
        if (to || hs2 != rv + 11 || dat !== 32'hCAFE0300) begin
            failures++;
            $display("FAIL second_ar_after_r timeout=%0d hs=%0d rdata=%h required hs=%0d rdata=cafe0300",
                     to, hs2, dat, rv + 11);
        end
    endtask

    task automatic test_back_to_back();
        int hs, rv, prev_hs;
        logic [DW-1:0] dat;
        logic [1:0] rsp;
        logic [AW-1:0] a;
        bit okst, to;
        for (int d = 0; d < 2; d++) begin
            prev_hs = -1;
            for (int i = 0; i < 4; i++) begin
                a = (d == 0) ? 24'($urandom()) : 24'($urandom_range(0, 63));
                run_read(d, a, 0, 1'b1, '0, 1'b0, hs, rv, dat, rsp, okst, to);
                checks++;
                if (to || dat !== mem_word(a) || (prev_hs >= 0 && hs - prev_hs != lat_of(d) + 3)) begin
                    failures++;
                    $display("FAIL back_to_back[%0d.%0d] timeout=%0d rdata=%h spacing=%0d required rdata=%h spacing=%0d",
                             d, i, to, dat, hs - prev_hs, mem_word(a), lat_of(d) + 3);
                end
                prev_hs = hs;
            end
        end
    endtask

    task automatic test_random();
        int hs, rv, c0, d, st, exp_lat;
        logic [DW-1:0] dat, exp_dat;
        logic [1:0] rsp, exp_rsp;
        logic [AW-1:0] a;
        bit okst, to, early, hit;
        for (int i = 0; i < 30; i++) begin
            d     = int'($urandom_range(0, 1));
            a     = (d == 0) ? 24'($urandom()) : 24'($urandom_range(0, 127));
            st    = int'($urandom_range(0, 3));
            early = (st == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            hit   = int'(a >> 2) < words_of(d);
            exp_dat = hit ? mem_word(a) : '0;
            exp_rsp = hit ? 2'b00 : 2'b10;
            exp_lat = hit ? lat_of(d) + 2 : 1;
            c0 = ren_cnt[d];
            run_read(d, a, st, early, '0, 1'b0, hs, rv, dat, rsp, okst, to);
            checks++;
            if (to || dat !== exp_dat || rsp !== exp_rsp || !okst) begin
                failures++;
                $display("FAIL random_resp[%0d] d=%0d addr=%h timeout=%0d stable=%0d got=%h/%b required=%h/%b",
                         i, d, a, to, okst, dat, rsp, exp_dat, exp_rsp);
            end
            checks++;
            if (rv - hs != exp_lat || ren_cnt[d] - c0 != (hit ? 1 : 0) || (hit && last_raddr[d] !== align(a))) begin
                failures++;
                $display("FAIL random_issue[%0d] d=%0d latency=%0d pulses=%0d raddr=%h required latency=%0d pulses=%0d raddr=%h",
                         i, d, rv - hs, ren_cnt[d] - c0, last_raddr[d], exp_lat, hit ? 1 : 0, align(a));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, seen;
        int hs, rv;
        logic [DW-1:0] dat;
        logic [1:0] rsp;
        bit okst, to;
        araddr[1] = 24'h000010; arvalid[1] = 1'b1; rready[1] = 1'b1;
        n = 0;
        while (arready[1] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rvalid[1] === 1'b1) seen++;
        end
        rready[1] = 1'b0;
        checks++;
        if (n >= 40 || seen != 0) begin
            failures++;
            $display("FAIL reset_in_wait ar_timeout=%0d rvalid_cycles=%0d required 0", n >= 40, seen);
        end
        for (int d = 0; d < 2; d++) begin
            run_read(d, 24'h000008, 0, 1'b0, '0, 1'b0, hs, rv, dat, rsp, okst, to);
            checks++;
            if (to || dat !== 32'hCAFE0008 || rsp !== 2'b00) begin
                failures++;
                $display("FAIL read_after_reset[%0d] timeout=%0d got=%h/%b required=cafe0008/00", d, to, dat, rsp);
            end
        end
    endtask

    task automatic test_protocol_rules();
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL protocol_rules violations=%0d required=0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_range_boundary();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge clk);
        test_protocol_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_read_controller.md
AXIL_READ_CONTROLLER -- requirements
Module: axil_read_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter READ_LATENCY, default 1, memory cycles from ren to rdata valid; legal range 1..4.
REQ-004 SHALL have parameter MEM_WORDS, default 2**22, number of addressable words.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports axil_araddr (input, ADDR_WIDTH), axil_arprot (input, 3, ignored), axil_arvalid (input, 1) and axil_arready (output, 1).
REQ-009 SHALL have ports axil_rdata (output, DATA_WIDTH), axil_rresp (output, 2), axil_rvalid (output, 1) and axil_rready (input, 1).
REQ-010 SHALL have port raddr, output, ADDR_WIDTH, memory word-aligned byte address.
REQ-011 SHALL have port ren, output, 1, one-cycle memory read strobe.
REQ-012 SHALL have port rdata, input, DATA_WIDTH, memory read data.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT, RESP, ERR.
REQ-014 IDLE: axil_arready=1; on arvalid&&arready SHALL latch araddr with bits [1:0] forced to 0.
- In-range address (word index < MEM_WORDS) -> ISSUE.
- Otherwise -> ERR.
REQ-015 ISSUE (exactly one cycle): ren=1, raddr=latched address; SHALL load latency counter with READ_LATENCY-1 and go to WAIT.
REQ-016 WAIT: SHALL decrement the counter each cycle; in the cycle it reads 0, capture rdata into the response register and go to RESP.
- Captured data = memory data READ_LATENCY cycles after the ren cycle.
REQ-017 RESP: axil_rvalid=1, axil_rresp=2'b00, axil_rdata=captured data, held stable until rready; on rvalid&&rready -> IDLE.
REQ-018 ERR: axil_rvalid=1, axil_rresp=2'b10 (SLVERR), axil_rdata=0, ren never asserted; on rready -> IDLE.
REQ-019 axil_arready SHALL be 0 in every state except IDLE: one outstanding read, no AR acceptance while a response is pending.
REQ-020 Outside ISSUE, ren SHALL be 0 and raddr SHALL be 0.
REQ-021 Outside RESP/ERR, axil_rvalid SHALL be 0 and axil_rdata/axil_rresp SHALL be 0.
REQ-022 Minimum AR-handshake-to-rvalid latency SHALL be READ_LATENCY+2 cycles; with rready held high, back-to-back throughput SHALL be one read per READ_LATENCY+3 cycles.
REQ-023 rready asserted before rvalid SHALL have no effect.
REQ-024 Response SHALL not be dropped or altered while rvalid=1 and rready=0, for any number of stall cycles.

Reset
REQ-025 On rst=1, asynchronously: state=IDLE, counter=0, latched address=0, response data=0, resp=0.
REQ-026 During reset, all outputs SHALL be 0, except axil_arready, which SHALL be 0 while rst=1 and 1 from the first cycle after deassertion.
REQ-027 A reset mid-transaction (ISSUE/WAIT/RESP/ERR) SHALL abandon the transaction with no response; the next AR after reset SHALL be served normally.

Structure
REQ-028 Package gpu_axil_pkg SHALL hold the resp constants (OKAY=2'b00, SLVERR=2'b10) and the read FSM state enum, shared with the write-side controller.
REQ-029 SHALL be a single module with no sub-modules; the latency counter width SHALL be 2 bits.

Verification
REQ-030 With READ_LATENCY=1, memory model returning 0xCAFE0000|addr: araddr=0x000104, rready=1 -> ren pulse with raddr=0x000104 for one cycle; rdata=0xCAFE0104, rresp=0, rvalid 3 cycles after the AR handshake.
REQ-031 araddr=0x000107 -> raddr=0x000104.
REQ-032 MEM_WORDS=16, araddr=0x000040 -> no ren; rresp=2'b10, rdata=0.
REQ-033 rready held low 10 cycles after rvalid -> rvalid, rdata and rresp stable; arready=0 throughout; a second arvalid is not accepted until after the R handshake.
REQ-034 READ_LATENCY=3, memory data valid exactly 3 cycles after ren, other cycles driving 0xDEADBEEF -> captured data is the correct word, never 0xDEADBEEF.
REQ-035 rst asserted in WAIT -> rvalid never rises for that read; after release, read of 0x000008 returns 0xCAFE0008.
